// File: rtl/wavegen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wavegen_pkg
// Purpose  : Shared types and constants for the square-wave sweep sequencer.
// Revision : 1.0
// ============================================================================
package wavegen_pkg;

    localparam int ACC_W_DEF = 32;

    localparam logic [7:0] DUTY_10 = 8'h00;
    localparam logic [7:0] DUTY_25 = 8'h01;
    localparam logic [7:0] DUTY_50 = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wavegen_phase_acc.sv
`default_nettype none
// ============================================================================
// Module   : wavegen_phase_acc
// Purpose  : Phase accumulator with synchronous clear and enable; wraps mod 2^ACC_W.
// Revision : 1.0
// ============================================================================
module wavegen_phase_acc #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] step,
    output logic [ACC_W-1:0] acc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + step;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wavegen_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wavegen_sweep_ctrl
// Purpose  : Steps the phase increment of the square-wave generator from a
//            start to a stop value with programmable dwell, pause and abort.
// Revision : 1.0
// ============================================================================
module wavegen_sweep_ctrl
    import wavegen_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_start_step,
    input  logic [ACC_W-1:0]   cfg_stop_step,
    input  logic [ACC_W-1:0]   cfg_delta,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [7:0]         cfg_duty,
    input  logic               cfg_loop,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [ACC_W-1:0]   phase_acc,
    output logic [7:0]         duty_cycle,
    output logic               wave_en,
    output logic               busy,
    output logic               sweep_done
);

    state_t state, state_nxt;

    logic [ACC_W-1:0]   sh_start, sh_stop, sh_delta, cur_step;
    logic [DWELL_W-1:0] sh_dwell, dwell_cnt, dwell_reload;
    logic [7:0]         sh_duty;
    logic               sh_loop, cfg_loaded;

    logic               go, run_step, finish, nxt_ok;
    logic [ACC_W:0]     nxt_step;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // A programmed dwell of zero behaves exactly like a dwell of one.
    assign dwell_reload = (sh_dwell == '0) ? '0 : sh_dwell - DWELL_W'(1);
    assign nxt_step     = {1'b0, cur_step} + {1'b0, sh_delta};
    assign nxt_ok       = !nxt_step[ACC_W] && (nxt_step[ACC_W-1:0] <= sh_stop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        run_step  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && cfg_loaded && !abort) begin
                    go        = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    run_step = 1'b1;
                    if ((dwell_cnt == '0) && !nxt_ok && !sh_loop) begin
                        finish    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (!pause) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_start   <= '0;
            sh_stop    <= '0;
            sh_delta   <= '0;
            sh_dwell   <= '0;
            sh_duty    <= '0;
            sh_loop    <= 1'b0;
            cfg_loaded <= 1'b0;
            cur_step   <= '0;
            dwell_cnt  <= '0;
            duty_cycle <= DUTY_50;
            wave_en    <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                sh_start   <= cfg_start_step;
                sh_stop    <= cfg_stop_step;
                sh_delta   <= cfg_delta;
                sh_dwell   <= cfg_dwell;
                sh_duty    <= cfg_duty;
                sh_loop    <= cfg_loop;
                cfg_loaded <= 1'b1;
            end
            // The gate follows the state we are entering, so abort and
            // completion both drop it on the same edge that leaves RUN/PAUSE.
            wave_en    <= (state_nxt != ST_IDLE);
            sweep_done <= finish;
            if (go) begin
                cur_step   <= sh_start;
                dwell_cnt  <= dwell_reload;
                duty_cycle <= sh_duty;
            end else if (run_step) begin
                if (dwell_cnt != '0) begin
                    dwell_cnt <= dwell_cnt - DWELL_W'(1);
                end else if (nxt_ok) begin
                    cur_step  <= nxt_step[ACC_W-1:0];
                    dwell_cnt <= dwell_reload;
                end else if (sh_loop) begin
                    cur_step  <= sh_start;
                    dwell_cnt <= dwell_reload;
                end
            end
        end
    end

    wavegen_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (go),
        .en    (run_step),
        .step  (cur_step),
        .acc   (phase_acc)
    );

endmodule
`default_nettype wire

// File: tb/tb_wavegen_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wavegen_sweep_ctrl
// Purpose  : Scoreboard bench for the sweep sequencer with directed sweeps.
// Revision : 1.0
// ============================================================================
module tb_wavegen_sweep_ctrl;

    localparam int ACC_W   = 32;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [ACC_W-1:0]   cfg_start_step = '0;
    logic [ACC_W-1:0]   cfg_stop_step = '0;
    logic [ACC_W-1:0]   cfg_delta = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [7:0]         cfg_duty = '0;
    logic               cfg_loop = 1'b0;
    logic               start = 1'b0;
    logic               pause = 1'b0;
    logic               abort = 1'b0;
    logic [ACC_W-1:0]   phase_acc;
    logic [7:0]         duty_cycle;
    logic               wave_en;
    logic               busy;
    logic               sweep_done;

    wavegen_sweep_ctrl #(
        .ACC_W   (ACC_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_start_step (cfg_start_step),
        .cfg_stop_step  (cfg_stop_step),
        .cfg_delta      (cfg_delta),
        .cfg_dwell      (cfg_dwell),
        .cfg_duty       (cfg_duty),
        .cfg_loop       (cfg_loop),
        .start          (start),
        .pause          (pause),
        .abort          (abort),
        .phase_acc      (phase_acc),
        .duty_cycle     (duty_cycle),
        .wave_en        (wave_en),
        .busy           (busy),
        .sweep_done     (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ph;
        logic [7:0]  duty;
    } exp_t;

    exp_t        wq[$];
    logic [31:0] dq[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each cycle the generator is gated on, the expected phase/duty is popped.
    always @(negedge clk) begin
        if (wave_en === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_wave_en", 32'(wave_en), 32'd0);
            end else begin
                e = wq.pop_front();
                check("phase_acc", phase_acc, e.ph);
                check("duty_cycle", 32'(duty_cycle), 32'(e.duty));
            end
        end
        if (sweep_done === 1'b1) begin
            if (dq.size() == 0) begin
                check("unexpected_sweep_done", 32'(sweep_done), 32'd0);
            end else begin
                check("done_phase_acc", phase_acc, dq.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_w(input logic [31:0] ph, input logic [7:0] duty);
        exp_t x;
        x.ph   = ph;
        x.duty = duty;
        wq.push_back(x);
    endtask

    task automatic load_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] d,
                            input logic [15:0] dw, input logic [7:0] du, input logic lp);
        cfg_start_step = s;
        cfg_stop_step  = p;
        cfg_delta      = d;
        cfg_dwell      = dw;
        cfg_duty       = du;
        cfg_loop       = lp;
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sweep_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a_exp [9];
        a_exp = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0500_0000,
                  32'h0700_0000, 32'h0900_0000, 32'h0C00_0000, 32'h0F00_0000};

        // Reset values while reset is held.
        #12;
        check("rst_phase_acc", phase_acc, 32'd0);
        check("rst_duty", 32'(duty_cycle), 32'h02);
        check("rst_wave_en", 32'(wave_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Start with no configuration ever loaded.
        start = 1'b1;
        repeat (3) tick();
        check("nocfg_busy", 32'(busy), 32'd0);
        check("nocfg_wave_en", 32'(wave_en), 32'd0);
        start = 1'b0;

        // Single sweep: steps 1,2,3 (<<24), dwell 3, duty 10%.
        load_cfg(32'h0100_0000, 32'h0300_0000, 32'h0100_0000, 16'd3, 8'h00, 1'b0);
        foreach (a_exp[i]) push_w(a_exp[i], 8'h00);
        dq.push_back(32'h1200_0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        check("cfg_ready_run", 32'(cfg_ready), 32'd0);
        // Offer the next config while the sweep is running.
        cfg_start_step = 32'h10;
        cfg_stop_step  = 32'h40;
        cfg_delta      = 32'h10;
        cfg_dwell      = 16'd0;
        cfg_duty       = 8'h01;
        cfg_loop       = 1'b0;
        cfg_valid      = 1'b1;
        wait_done("sweep_a");
        check("cfg_ready_at_done", 32'(cfg_ready), 32'd1);
        check("wave_en_at_done", 32'(wave_en), 32'd0);

        // Dwell 0, duty 25%: step changes every cycle.
        push_w(32'h00, 8'h01);
        push_w(32'h10, 8'h01);
        push_w(32'h30, 8'h01);
        push_w(32'h60, 8'h01);
        dq.push_back(32'hA0);
        tick();
        cfg_valid = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done("sweep_b");
        tick();
        check("sweep_b_queue_empty", 32'(wq.size()), 32'd0);

        // Abort in IDLE together with start: nothing happens.
        abort = 1'b1;
        start = 1'b1;
        repeat (2) tick();
        check("idle_abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        start = 1'b0;

        // Looping sweep where the delta add carries out.
        load_cfg(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 16'd1, 8'h05, 1'b1);
        for (int i = 0; i < 6; i++) push_w((i % 2 == 0) ? 32'h0 : 32'h8000_0000, 8'h05);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("loop_abort_wave_en", 32'(wave_en), 32'd0);
        check("loop_abort_busy", 32'(busy), 32'd0);
        check("loop_abort_phase", phase_acc, 32'h8000_0000);

        // Pause mid-dwell for 5 cycles, then abort together with pause.
        load_cfg(32'h100, 32'h300, 32'h100, 16'd3, 8'h00, 1'b0);
        push_w(32'h000, 8'h00);
        for (int i = 0; i < 7; i++) push_w(32'h100, 8'h00);
        push_w(32'h200, 8'h00);
        push_w(32'h300, 8'h00);
        push_w(32'h500, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pause = 1'b1;
        repeat (5) tick();
        pause = 1'b0;
        repeat (4) tick();
        pause = 1'b1;
        abort = 1'b1;
        tick();
        pause = 1'b0;
        abort = 1'b0;
        check("pause_abort_wave_en", 32'(wave_en), 32'd0);
        check("pause_abort_busy", 32'(busy), 32'd0);
        check("pause_abort_phase", phase_acc, 32'h500);

        // Asynchronous reset in the middle of a sweep.
        load_cfg(32'h100, 32'h300, 32'h100, 16'd3, 8'h03, 1'b0);
        push_w(32'h000, 8'h03);
        push_w(32'h100, 8'h03);
        push_w(32'h200, 8'h03);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_phase_acc", phase_acc, 32'd0);
        check("midrst_duty", 32'(duty_cycle), 32'h02);
        check("midrst_wave_en", 32'(wave_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        check("midrst_cfg_cleared_busy", 32'(busy), 32'd0);
        start = 1'b0;
        tick();

        check("final_wave_queue_empty", 32'(wq.size()), 32'd0);
        check("final_done_queue_empty", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
